// File: rtl/i2c_config_seq_pkg.sv
// Shared types and constants for the I2C configuration sequencer.
// State encoding plus the table's end and delay marker words.
package i2c_config_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_LAUNCH,
    S_RELEASE,
    S_WAIT_LOW,
    S_WAIT_HIGH,
    S_CHECK,
    S_NEXT,
    S_FINISH,
    S_ABORT
  } state_e;

  localparam logic [15:0] END_MARKER   = 16'hFFFF;
  localparam logic [15:0] DELAY_MARKER = 16'hFFF0;

endpackage

// File: rtl/i2c_config_seq_if.sv
// Request/status bundle between the sequencer and the I2C write engine.
// The sequencer is the master; the engine is the slave.
interface i2c_config_seq_if;
  logic        i2c_enable;
  logic [15:0] i2c_reg_data;
  logic [7:0]  i2c_sl_addr;
  logic [7:0]  i2c_byte_num;
  logic        i2c_end;
  logic        i2c_nack;

  modport master (
    output i2c_enable,
    output i2c_reg_data,
    output i2c_sl_addr,
    output i2c_byte_num,
    input  i2c_end,
    input  i2c_nack
  );

  modport slave (
    input  i2c_enable,
    input  i2c_reg_data,
    input  i2c_sl_addr,
    input  i2c_byte_num,
    output i2c_end,
    output i2c_nack
  );
endinterface

// File: rtl/i2c_config_lut.sv
// Registered configuration ROM; data follows addr by one clock.
// Unlisted addresses read as the end marker.
module i2c_config_lut
  import i2c_config_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  addr,
  output logic [15:0] data
);

  logic [15:0] data_d;
  logic [15:0] data_q;

  always_comb begin
    data_d = END_MARKER;
    case (addr)
      8'd0:    data_d = 16'h2001;
      8'd1:    data_d = 16'h0A05;
      8'd2:    data_d = DELAY_MARKER;
      8'd3:    data_d = 16'h1234;
      8'd4:    data_d = 16'h0C0F;
      8'd5:    data_d = 16'h1E00;
      default: data_d = END_MARKER;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) data_q <= '0;
    else        data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/i2c_config_seq.sv
// Walks the configuration table and issues each word to the I2C engine,
// retrying NACKed entries and aborting on exhausted retries or timeout.
module i2c_config_seq
  import i2c_config_seq_pkg::*;
#(
  parameter logic [7:0]  LUT_SIZE   = 8'd64,
  parameter logic [7:0]  SLAVE_ADDR = 8'hBA,
  parameter logic [7:0]  BYTE_NUM   = 8'd2,
  parameter int unsigned MAX_RETRY  = 3,
  parameter logic [15:0] TIMEOUT    = 16'd50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [7:0]       lut_index,
  input  logic [15:0]      lut_data,
  i2c_config_seq_if.master i2c,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [7:0]       fail_index
);

  localparam logic [7:0] MAX_R = 8'(MAX_RETRY);

  state_e      state_d, state_q;
  logic [7:0]  idx_d, idx_q;
  logic [15:0] data_d, data_q;
  logic [7:0]  retry_d, retry_q;
  logic [15:0] tmo_d, tmo_q;
  logic        fetch_d, fetch_q;
  logic        en_d, en_q;
  logic        busy_d, busy_q;
  logic        done_d, done_q;
  logic        err_d, err_q;
  logic [7:0]  fail_d, fail_q;
  logic        tmo_hit;

  assign tmo_hit = (tmo_q == TIMEOUT - 16'd1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    retry_d = retry_q;
    tmo_d   = '0;
    fetch_d = 1'b0;
    en_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    fail_d  = fail_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          retry_d = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = S_FETCH;
        end
      end
      // first cycle lets the registered table catch up with idx
      S_FETCH: begin
        if (!fetch_q) begin
          fetch_d = 1'b1;
        end else begin
          data_d  = lut_data;
          state_d = (lut_data == END_MARKER) ? S_FINISH : S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (i2c.i2c_end) begin
          en_d    = 1'b1;
          state_d = S_RELEASE;
        end else if (tmo_hit) begin
          state_d = S_ABORT;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_RELEASE: state_d = S_WAIT_LOW;
      S_WAIT_LOW: begin
        if (!i2c.i2c_end)  state_d = S_WAIT_HIGH;
        else if (tmo_hit)  state_d = S_ABORT;
        else               tmo_d   = tmo_q + 16'd1;
      end
      S_WAIT_HIGH: begin
        if (i2c.i2c_end)   state_d = S_CHECK;
        else if (tmo_hit)  state_d = S_ABORT;
        else               tmo_d   = tmo_q + 16'd1;
      end
      S_CHECK: begin
        if (!i2c.i2c_nack) begin
          retry_d = '0;
          state_d = S_NEXT;
        end else if (retry_q < MAX_R) begin
          retry_d = retry_q + 8'd1;
          state_d = S_LAUNCH;
        end else begin
          state_d = S_ABORT;
        end
      end
      S_NEXT: begin
        if (idx_q == LUT_SIZE - 8'd1) begin
          state_d = S_FINISH;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = S_FETCH;
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_ABORT: begin
        err_d   = 1'b1;
        busy_d  = 1'b0;
        fail_d  = idx_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      retry_q <= '0;
      tmo_q   <= '0;
      fetch_q <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      retry_q <= retry_d;
      tmo_q   <= tmo_d;
      fetch_q <= fetch_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  assign lut_index        = idx_q;
  assign i2c.i2c_enable   = en_q;
  assign i2c.i2c_reg_data = data_q;
  assign i2c.i2c_sl_addr  = SLAVE_ADDR;
  assign i2c.i2c_byte_num = BYTE_NUM;
  assign busy             = busy_q;
  assign done             = done_q;
  assign error            = err_q;
  assign fail_index       = fail_q;

endmodule

// File: tb/tb_i2c_config_seq.sv
// Bench for i2c_config_seq: engine model, table model and a
// transaction-level expectation of issued words and final status.
module tb_i2c_config_seq;
  import i2c_config_seq_pkg::*;

  localparam int LUTN = 4;
  localparam int MAXR = 3;
  localparam int TMO  = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  lut_index, fail_index;
  logic [15:0] lut_data, rom_data, tbl_q;
  logic        busy, done, error;
  bit          use_rom = 1'b0;

  i2c_config_seq_if bus();

  i2c_config_seq #(
    .LUT_SIZE(8'(LUTN)),
    .SLAVE_ADDR(8'hBA),
    .BYTE_NUM(8'd2),
    .MAX_RETRY(MAXR),
    .TIMEOUT(16'(TMO))
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .start(start),
    .lut_index(lut_index),
    .lut_data(lut_data),
    .i2c(bus),
    .busy(busy),
    .done(done),
    .error(error),
    .fail_index(fail_index)
  );

  i2c_config_lut rom (
    .clk(clk),
    .reset(rst_n),
    .addr(lut_index),
    .data(rom_data)
  );

  always #5 clk = ~clk;

  logic [15:0] tbl [0:255];
  always @(posedge clk) tbl_q <= tbl[lut_index];
  assign lut_data = use_rom ? rom_data : tbl_q;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // engine model
  int nacks [0:255];
  int ptr, ncnt, eng_txn, phase, dly;
  bit stuck, long_low;

  always @(negedge clk) begin
    if (!rst_n) begin
      bus.i2c_end  = 1'b1;
      bus.i2c_nack = 1'b0;
      phase = 0;
    end else begin
      case (phase)
        0: if (bus.i2c_enable && !stuck) begin
          dly = $urandom_range(1, 3);
          phase = 1;
        end
        1: begin
          dly--;
          if (dly == 0) begin
            bus.i2c_end = 1'b0;
            eng_txn++;
            dly = long_low ? 10 : $urandom_range(1, 5);
            phase = 2;
          end
        end
        default: begin
          dly--;
          if (dly == 0) begin
            if (ncnt < nacks[ptr]) begin
              bus.i2c_nack = 1'b1;
              ncnt++;
            end else begin
              bus.i2c_nack = 1'b0;
              ncnt = 0;
              ptr++;
            end
            bus.i2c_end = 1'b1;
            phase = 0;
          end
        end
      endcase
    end
  end

  // expectation model
  logic [15:0] exp_q [$];
  bit          exp_done, exp_err;
  logic [7:0]  exp_fail, exp_idx;

  task automatic build_model();
    int n;
    exp_q.delete();
    exp_done = 0;
    exp_err  = 0;
    exp_idx  = 8'(LUTN - 1);
    for (int i = 0; i < LUTN; i++) begin
      if (tbl[i] == END_MARKER) begin
        exp_done = 1;
        exp_idx  = 8'(i);
        return;
      end
      n = (nacks[i] > MAXR) ? MAXR + 1 : nacks[i] + 1;
      repeat (n) exp_q.push_back(tbl[i]);
      if (nacks[i] > MAXR) begin
        exp_err  = 1;
        exp_fail = 8'(i);
        exp_idx  = 8'(i);
        return;
      end
    end
    exp_done = 1;
  endtask

  // compare process
  int cyc = 0;
  int en_cyc = 0;
  int n_pulse = 0;
  bit prev_en = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (bus.i2c_enable) begin
        en_cyc = cyc;
        n_pulse++;
        check("en_one_cycle", 32'(prev_en), 0);
        check("busy_in_run", 32'(busy), 1);
        check("sl_addr", 32'(bus.i2c_sl_addr), 32'h0BA);
        check("byte_num", 32'(bus.i2c_byte_num), 2);
        check("pulse_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0)
          check("reg_data", 32'(bus.i2c_reg_data), 32'(exp_q.pop_front()));
      end
      prev_en = bus.i2c_enable;
    end else begin
      prev_en = 0;
    end
  end

  task automatic rand_table(input bit markers);
    int r;
    for (int i = 0; i < LUTN; i++) begin
      r = $urandom_range(0, 7);
      tbl[i] = 16'($urandom_range(0, 16'hFFEF));
      if (markers && r == 0) tbl[i] = END_MARKER;
      if (markers && r == 1) tbl[i] = DELAY_MARKER;
      nacks[i] = 0;
    end
  endtask

  task automatic run_and_check(input string tag, input bit extra);
    int k;
    ptr = 0;
    ncnt = 0;
    n_pulse = 0;
    build_model();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!(done || error) && k < 3000) begin
      @(negedge clk);
      start = 1'b0;
      k++;
      if (extra && busy && $urandom_range(0, 15) == 0) start = 1'b1;
    end
    start = 1'b0;
    check({tag, "_finished"}, 32'(k < 3000), 1);
    check({tag, "_all_issued"}, 32'(exp_q.size()), 0);
    check({tag, "_done"}, 32'(done), 32'(exp_done));
    check({tag, "_error"}, 32'(error), 32'(exp_err));
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_lut_index"}, 32'(lut_index), 32'(exp_idx));
    check({tag, "_fail_index"}, 32'(fail_index), 32'(exp_fail));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, lat, base;
    for (int i = 0; i < 256; i++) begin
      tbl[i] = END_MARKER;
      nacks[i] = 0;
    end
    stuck = 0;
    long_low = 0;
    eng_txn = 0;
    exp_fail = '0;

    #3 rst_n = 1'b0;
    #1;
    check("rst_lut_index", 32'(lut_index), 0);
    check("rst_enable", 32'(bus.i2c_enable), 0);
    check("rst_reg_data", 32'(bus.i2c_reg_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_fail_index", 32'(fail_index), 0);
    check("rst_sl_addr", 32'(bus.i2c_sl_addr), 32'h0BA);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // ROM table, everything ACKed, includes a delay entry
    use_rom = 1'b1;
    tbl[0] = 16'h2001;
    tbl[1] = 16'h0A05;
    tbl[2] = 16'hFFF0;
    tbl[3] = 16'h1234;
    build_model();
    check("model_rom_len", 32'(exp_q.size()), 4);
    run_and_check("rom", 0);
    check("rom_pulses", 32'(n_pulse), 4);
    use_rom = 1'b0;

    // entry 1 NACKed twice then ACKed
    rand_table(0);
    nacks[1] = 2;
    run_and_check("retry", 0);
    check("retry_pulses", 32'(n_pulse), 6);

    // engine stuck idle: timeout in WAIT_LOW, extra start ignored
    rand_table(0);
    stuck = 1;
    ptr = 0;
    n_pulse = 0;
    exp_q.delete();
    exp_q.push_back(tbl[0]);
    exp_fail = 8'd0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    lat = 0;
    while (!error && k < 500) begin
      @(negedge clk);
      start = (k == 20);
      k++;
    end
    start = 1'b0;
    lat = cyc - en_cyc;
    check("tmo_reached", 32'(error), 1);
    check("tmo_latency_ok", 32'(lat >= 95 && lat <= 110), 1);
    check("tmo_done", 32'(done), 0);
    check("tmo_busy", 32'(busy), 0);
    check("tmo_fail_index", 32'(fail_index), 0);
    check("tmo_pulses", 32'(n_pulse), 1);
    stuck = 0;
    repeat (3) @(negedge clk);

    // entry 2 always NACKed
    rand_table(0);
    nacks[2] = 99;
    run_and_check("abort", 0);
    check("abort_pulses", 32'(n_pulse), 6);
    check("abort_fail_lit", 32'(fail_index), 2);

    // reset during WAIT_HIGH of the second entry
    rand_table(0);
    long_low = 1;
    ptr = 0;
    ncnt = 0;
    build_model();
    base = eng_txn;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!(eng_txn == base + 2 && !bus.i2c_end) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("mid_reached", 32'(k < 1000), 1);
    repeat (2) @(negedge clk);
    check("mid_busy_before", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_lut_index", 32'(lut_index), 0);
    check("mid_rst_enable", 32'(bus.i2c_enable), 0);
    check("mid_rst_reg_data", 32'(bus.i2c_reg_data), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_error", 32'(error), 0);
    check("mid_rst_fail_index", 32'(fail_index), 0);
    exp_q.delete();
    exp_fail = '0;
    long_low = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_and_check("after_rst", 0);
    check("after_rst_pulses", 32'(n_pulse), 4);

    // end marker at entry 1
    rand_table(0);
    tbl[1] = END_MARKER;
    run_and_check("endmark", 0);
    check("endmark_pulses", 32'(n_pulse), 1);
    check("endmark_idx_lit", 32'(lut_index), 1);
    check("endmark_data_lit", 32'(bus.i2c_reg_data), 32'h0FFFF);

    // randomized runs with markers, retries and ignored starts
    for (int r = 0; r < 12; r++) begin
      rand_table(1);
      for (int i = 0; i < LUTN; i++)
        nacks[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      run_and_check($sformatf("rnd%0d", r), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
